// File: rtl/logic_op_sequencer.sv
// Sequences the shared AND/OR/XOR/NOT logic unit through a masked list of ops on
// one latched operand pair, holding each op for DWELL cycles and capturing its result.
module logic_op_sequencer #(
    parameter int DWELL = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] op_mask,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [1:0] lu_sel,
    output logic [7:0] lu_in,
    input  logic [8:0] lu_out,
    output logic [3:0] res_and,
    output logic [3:0] res_or,
    output logic [3:0] res_xor,
    output logic [7:0] res_not,
    output logic [3:0] valid_mask,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DN   = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] cnt;
    logic [1:0] idx;
    logic [3:0] a_reg, b_reg, mask_reg;

    logic       accept;
    logic       last_tick;
    logic       nxt_found;
    logic [1:0] nxt_idx;
    logic [1:0] first_idx;
    logic       unused_lu;

    assign unused_lu = lu_out[8];
    assign accept    = (state == IDLE) && start;
    assign last_tick = (state == RUN) && (cnt == 8'(DWELL - 1));

    // Lowest set bit of the incoming mask picks the first op of a run.
    always_comb begin
        first_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (op_mask[i]) first_idx = 2'(i);
        end
    end

    // Next higher selected op after the one currently on the unit.
    always_comb begin
        nxt_found = 1'b0;
        nxt_idx   = idx;
        for (int i = 3; i >= 0; i--) begin
            if (mask_reg[i] && (2'(i) > idx)) begin
                nxt_found = 1'b1;
                nxt_idx   = 2'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = (op_mask == 4'd0) ? DN : RUN;
            RUN:  if (last_tick && !nxt_found) state_nxt = DN;
            DN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN);
        done = (state == DN);
    end

    // Operand latch, dwell counter, op index and result capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg      <= 4'd0;
            b_reg      <= 4'd0;
            mask_reg   <= 4'd0;
            cnt        <= 8'd0;
            idx        <= 2'd0;
            res_and    <= 4'd0;
            res_or     <= 4'd0;
            res_xor    <= 4'd0;
            res_not    <= 8'd0;
            valid_mask <= 4'd0;
        end else if (accept) begin
            a_reg      <= a;
            b_reg      <= b;
            mask_reg   <= op_mask;
            valid_mask <= 4'd0;
            cnt        <= 8'd0;
            if (op_mask != 4'd0) idx <= first_idx;
        end else if (state == RUN) begin
            if (last_tick) begin
                case (idx)
                    2'd0: res_and <= lu_out[3:0];
                    2'd1: res_or  <= lu_out[3:0];
                    2'd2: res_xor <= lu_out[3:0];
                    default: res_not <= lu_out[7:0];
                endcase
                valid_mask[idx] <= 1'b1;
                cnt             <= 8'd0;
                if (nxt_found) idx <= nxt_idx;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    assign lu_sel = idx;
    assign lu_in  = {b_reg, a_reg};

endmodule

// File: tb/tb_logic_op_sequencer.sv
// Directed bench for logic_op_sequencer: DWELL=4 instance for the main scenarios,
// DWELL=1 instance for the back-to-back repeat case; the logic unit is modelled here.
module tb_logic_op_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] op_mask = 4'd0, a = 4'd0, b = 4'd0;

    logic [1:0] lu_sel, lu_sel1;
    logic [7:0] lu_in, lu_in1;
    logic [8:0] lu_out, lu_out1;
    logic [3:0] res_and, res_or, res_xor, valid_mask;
    logic [7:0] res_not;
    logic       busy, done;
    logic [3:0] res_and1, res_or1, res_xor1, valid_mask1;
    logic [7:0] res_not1;
    logic       busy1, done1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Logic unit model; bit 8 is driven as junk the sequencer must ignore.
    function automatic logic [8:0] lu_model(input logic [1:0] sel, input logic [7:0] x);
        case (sel)
            2'd0: return {1'b1, 4'd0, x[7:4] & x[3:0]};
            2'd1: return {1'b1, 4'd0, x[7:4] | x[3:0]};
            2'd2: return {1'b1, 4'd0, x[7:4] ^ x[3:0]};
            default: return {1'b1, ~x};
        endcase
    endfunction

    assign lu_out  = lu_model(lu_sel, lu_in);
    assign lu_out1 = lu_model(lu_sel1, lu_in1);

    logic_op_sequencer #(.DWELL(4)) dut (
        .clk(clk), .rst(rst), .start(start), .op_mask(op_mask), .a(a), .b(b),
        .lu_sel(lu_sel), .lu_in(lu_in), .lu_out(lu_out),
        .res_and(res_and), .res_or(res_or), .res_xor(res_xor), .res_not(res_not),
        .valid_mask(valid_mask), .busy(busy), .done(done)
    );

    logic_op_sequencer #(.DWELL(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .op_mask(op_mask), .a(a), .b(b),
        .lu_sel(lu_sel1), .lu_in(lu_in1), .lu_out(lu_out1),
        .res_and(res_and1), .res_or(res_or1), .res_xor(res_xor1), .res_not(res_not1),
        .valid_mask(valid_mask1), .busy(busy1), .done(done1)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        repeat (2) tick;
        checks++;
        if ({lu_sel, lu_in, res_and, res_or, res_xor, res_not, valid_mask, busy, done} !== 36'd0) begin
            errors++;
            $display("FAIL reset_state got sel=%b in=%h and=%h or=%h xor=%h not=%h vm=%b busy=%b done=%b exp all zero",
                     lu_sel, lu_in, res_and, res_or, res_xor, res_not, valid_mask, busy, done);
        end
        rst = 1'b0;
        tick;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset got busy=%b done=%b exp 0 0", busy, done);
        end
    endtask

    task automatic test_full;
        a = 4'b1100; b = 4'b1010; op_mask = 4'b1111; start = 1'b1;
        tick;
        start = 1'b0;
        checks++;
        if (lu_in !== 8'b1010_1100 || valid_mask !== 4'b0000) begin
            errors++;
            $display("FAIL full_accept got lu_in=%b vm=%b exp 10101100 0000", lu_in, valid_mask);
        end
        for (int c = 0; c < 16; c++) begin
            checks++;
            if (lu_sel !== 2'(c / 4) || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL full_step%0d got sel=%b busy=%b done=%b exp sel=%b busy=1 done=0",
                         c, lu_sel, busy, done, 2'(c / 4));
            end
            tick;
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || lu_sel !== 2'b11) begin
            errors++;
            $display("FAIL full_done got done=%b busy=%b sel=%b exp 1 0 11", done, busy, lu_sel);
        end
        checks++;
        if (res_and !== 4'b1000 || res_or !== 4'b1110 || res_xor !== 4'b0110 ||
            res_not !== 8'b0101_0011 || valid_mask !== 4'b1111) begin
            errors++;
            $display("FAIL full_results got and=%b or=%b xor=%b not=%b vm=%b exp 1000 1110 0110 01010011 1111",
                     res_and, res_or, res_xor, res_not, valid_mask);
        end
        tick;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || lu_sel !== 2'b11) begin
            errors++;
            $display("FAIL full_idle got done=%b busy=%b sel=%b exp 0 0 11", done, busy, lu_sel);
        end
    endtask

    task automatic test_partial;
        a = 4'b1100; b = 4'b1010; op_mask = 4'b0101; start = 1'b1;
        tick;
        start = 1'b0;
        checks++;
        if (valid_mask !== 4'b0000) begin
            errors++;
            $display("FAIL partial_clear got vm=%b exp 0000", valid_mask);
        end
        for (int c = 0; c < 8; c++) begin
            checks++;
            if (lu_sel !== ((c < 4) ? 2'b00 : 2'b10) || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL partial_step%0d got sel=%b busy=%b done=%b exp sel=%b busy=1 done=0",
                         c, lu_sel, busy, done, (c < 4) ? 2'b00 : 2'b10);
            end
            tick;
        end
        checks++;
        if (done !== 1'b1 || res_and !== 4'b1000 || res_xor !== 4'b0110 || valid_mask !== 4'b0101 ||
            res_or !== 4'b1110 || res_not !== 8'b0101_0011) begin
            errors++;
            $display("FAIL partial_done got done=%b and=%b xor=%b vm=%b or=%b not=%b exp 1 1000 0110 0101 1110 01010011",
                     done, res_and, res_xor, valid_mask, res_or, res_not);
        end
        tick;
    endtask

    task automatic test_zero_mask;
        op_mask = 4'b0000; start = 1'b1;
        tick;
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || valid_mask !== 4'b0000) begin
            errors++;
            $display("FAIL zero_done got done=%b busy=%b vm=%b exp 1 0 0000", done, busy, valid_mask);
        end
        tick;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || res_and !== 4'b1000) begin
            errors++;
            $display("FAIL zero_after got done=%b busy=%b and=%b exp 0 0 1000", done, busy, res_and);
        end
    endtask

    task automatic test_midrun_inputs;
        int ndone;
        int done_edge;
        ndone = 0;
        done_edge = -1;
        a = 4'b0000; b = 4'b1010; op_mask = 4'b1111; start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        tick;
        a = 4'b1111; b = 4'b0101; op_mask = 4'b0001; start = 1'b1;
        for (int e = 3; e <= 20; e++) begin
            tick;
            start = 1'b0;
            if (done === 1'b1) begin
                ndone++;
                done_edge = e;
            end
        end
        checks++;
        if (ndone != 1 || done_edge != 16) begin
            errors++;
            $display("FAIL midrun_done got count=%0d edge=%0d exp 1 16", ndone, done_edge);
        end
        checks++;
        if (res_and !== 4'b0000 || res_or !== 4'b1010 || res_xor !== 4'b1010 ||
            res_not !== 8'b0101_1111 || valid_mask !== 4'b1111 || lu_in !== 8'b1010_0000) begin
            errors++;
            $display("FAIL midrun_results got and=%b or=%b xor=%b not=%b vm=%b in=%b exp 0000 1010 1010 01011111 1111 10100000",
                     res_and, res_or, res_xor, res_not, valid_mask, lu_in);
        end
    endtask

    task automatic test_async_reset;
        int ndone;
        ndone = 0;
        a = 4'b1100; b = 4'b1010; op_mask = 4'b1111; start = 1'b1;
        tick;
        start = 1'b0;
        repeat (5) tick;
        checks++;
        if (lu_sel !== 2'b01 || busy !== 1'b1) begin
            errors++;
            $display("FAIL areset_pre got sel=%b busy=%b exp 01 1", lu_sel, busy);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({lu_sel, lu_in, res_and, res_or, res_xor, res_not, valid_mask, busy, done} !== 36'd0) begin
            errors++;
            $display("FAIL areset_mid got sel=%b in=%h and=%h or=%h xor=%h not=%h vm=%b busy=%b done=%b exp all zero",
                     lu_sel, lu_in, res_and, res_or, res_xor, res_not, valid_mask, busy, done);
        end
        #2 rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (done === 1'b1) ndone++;
        end
        checks++;
        if (ndone != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL areset_nodone got dones=%0d busy=%b exp 0 0", ndone, busy);
        end
    endtask

    task automatic test_back_to_back;
        a = 4'b1100; b = 4'b1010; op_mask = 4'b0001; start = 1'b1;
        for (int t = 0; t < 40; t++) begin
            tick;
            checks++;
            if (done1 !== (t % 3 == 1) || busy1 !== (t % 3 == 0)) begin
                errors++;
                $display("FAIL b2b_cycle%0d got done=%b busy=%b exp done=%b busy=%b",
                         t, done1, busy1, (t % 3 == 1), (t % 3 == 0));
            end
        end
        start = 1'b0;
        repeat (4) tick;
        checks++;
        if (res_and1 !== 4'b1000 || valid_mask1 !== 4'b0001 || lu_sel1 !== 2'b00 || done1 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_final got and=%b vm=%b sel=%b done=%b exp 1000 0001 00 0",
                     res_and1, valid_mask1, lu_sel1, done1);
        end
    endtask

    initial begin
        test_reset;
        test_full;
        test_partial;
        test_zero_mask;
        test_midrun_inputs;
        test_async_reset;
        test_full;
        repeat (6) tick;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/logic_op_sequencer.md
Name: logic_op_sequencer

Overview:
- Controller that sequences the shared 4-function logic unit (AND/OR/XOR/NOT, 2-bit select, 9-bit result) through a masked list of operations on one latched operand pair.
- Holds each op on the unit for a programmable dwell, captures each result into its own register and reports completion.
- Sits between board switch/key inputs and the logic unit. Drives the unit's select and operand inputs and reads its result bus.

Parameters:
- DWELL, 4, clock cycles each op is held on the logic unit before its result is captured; legal range 1..255

Ports:
- clk  input  1  system clock, all state changes on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a run; sampled only in IDLE
- op_mask  input  4  bit0=AND, bit1=OR, bit2=XOR, bit3=NOT; ops to run
- a  input  4  operand A (low nibble to unit)
- b  input  4  operand B (high nibble to unit)
- lu_sel  output  2  select to logic unit: 00 AND, 01 OR, 10 XOR, 11 NOT
- lu_in  output  8  operand bus to logic unit, {b_reg, a_reg}
- lu_out  input  9  result bus from logic unit
- res_and  output  4  captured AND result
- res_or  output  4  captured OR result
- res_xor  output  4  captured XOR result
- res_not  output  8  captured NOT result
- valid_mask  output  4  per-op result-valid flags, same bit order as op_mask
- busy  output  1  high while in RUN
- done  output  1  one-cycle completion pulse

Behaviour:
- Reset (async, any state):
  - state=IDLE, dwell counter=0, op index=0.
  - lu_sel=00, lu_in=0.
  - All res_* = 0, valid_mask=0, busy=0, done=0.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at an edge (accepting edge):
  - Latch a, b and op_mask into a_reg, b_reg, mask_reg.
  - Clear valid_mask. res_* keep their old values.
  - If op_mask=0: go to DONE.
  - Otherwise: go to RUN with op index = lowest set bit and counter=0.
- RUN:
  - busy=1. lu_sel=op index. lu_in={b_reg,a_reg}, stable for the whole run.
  - Counter increments each cycle.
  - At the edge where counter==DWELL-1, capture:
    - op0: lu_out[3:0] into res_and
    - op1: lu_out[3:0] into res_or
    - op2: lu_out[3:0] into res_xor
    - op3: lu_out[7:0] into res_not
  - On the same edge, set the matching valid_mask bit and reset counter to 0.
  - Then move to the next higher set bit of mask_reg. If none remain, go to DONE.
  - lu_out[8] is ignored.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- Handshake and latency:
  - start is ignored in RUN and DONE; it is not queued.
  - An accepted start with k selected ops (k=popcount) gives busy=1 from the cycle after the accepting edge.
  - done is high in the cycle beginning k*DWELL edges after the accepting edge.
  - For k=0, done is high in the cycle immediately after the accepting edge.
- Input changes: a, b and op_mask changes during RUN have no effect until the next accepted start.
- Output stability:
  - lu_sel holds its last value in DONE/IDLE; it changes only at op advance or reset.
  - res_* and valid_mask hold after DONE until the next accepted start or reset.
- Reset mid-RUN: abort immediately, all outputs go to reset values, no done pulse.
- start held high continuously: a new run is accepted at the first IDLE edge after DONE. Runs repeat with one IDLE cycle between them.

Test Plan:
- DWELL=4, a=1100, b=1010, mask=1111, bench models logic unit:
  - lu_sel steps 00,01,10,11, each held 4 cycles.
  - Captured: res_and=1000, res_or=1110, res_xor=0110, res_not=01010011.
  - valid_mask=1111; done pulses once, 16 edges after the accepting edge.
- mask=0101, same operands -> only lu_sel 00 then 10 appear; res_and=1000, res_xor=0110, valid_mask=0101, done 8 edges after accept, res_or/res_not unchanged.
- mask=0000 -> no RUN cycle, busy stays 0, done high in cycle after accept, valid_mask=0000.
- Mid-run stimulus: pulse start with a=0000 and change a, b and mask after 2 cycles of RUN -> ignored; results reflect the original latched values, exactly one done.
- Async rst asserted mid-cycle during the second op of a mask=1111 run -> outputs zero immediately without waiting for clk; no done. After release, a new start runs normally.
- start held high for 40 cycles, mask=0001, DWELL=1 -> repeated runs: accept, 1 RUN cycle, DONE, IDLE, accept; done pulses every 3 cycles.
